// File: rtl/rom_pkg.sv
// Shared constants, ROM text segment map and FSM state type for rom_reader.
package rom_pkg;

  localparam int ROM_ADDR_W = 6;
  localparam int ROM_DATA_W = 8;

  localparam logic [5:0] ROM_SEP_ADDR   = 6'd47;

  // Text segments held in the character ROM.
  localparam logic [5:0] SEG_ID_BASE    = 6'd0;
  localparam logic [5:0] SEG_ID_LEN     = 6'd9;
  localparam logic [5:0] SEG_FIRST_BASE = 6'd9;
  localparam logic [5:0] SEG_FIRST_LEN  = 6'd13;
  localparam logic [5:0] SEG_SURN_BASE  = 6'd29;
  localparam logic [5:0] SEG_SURN_LEN   = 6'd15;
  localparam logic [5:0] SEG_SPACE_BASE = 6'd47;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4
  } rd_state_e;

endpackage

// File: rtl/rom_reader_if.sv
// Segment request, ROM bus and byte-stream signals of rom_reader.
interface rom_reader_if
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] seg_base;
  logic [ADDR_W-1:0] seg_len;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_d;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, seg_base, seg_len, rom_d, out_ready,
    output rom_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, seg_base, seg_len, rom_d, out_ready,
    input  rom_addr, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/rom_reader_fsm.sv
// Control FSM of rom_reader: state, remaining-byte counter, registered busy/done/out_valid.
// ROM_READER_SEPARATOR_EN adds one trailing separator fetch after the segment.
module rom_reader_fsm
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] seg_len_i,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              out_valid_o,
  output logic              load_base_o,
  output logic              incr_addr_o,
`ifdef ROM_READER_SEPARATOR_EN
  output logic              load_sep_o,
`endif
  output logic              capture_o
);

  localparam logic [ADDR_W-1:0] LEN_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LEN_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  rd_state_e         state_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              idle_start_s;
  logic              hs_s;

  assign idle_start_s = (state_q == IDLE) && start_i;
  assign hs_s         = (state_q == SEND) && out_ready_i;
  assign load_base_o  = idle_start_s && (seg_len_i != LEN_ZERO);
  assign incr_addr_o  = hs_s && (remaining_q > LEN_ONE);
  assign capture_o    = (state_q == WAIT);
`ifdef ROM_READER_SEPARATOR_EN
  // remaining_q reaches zero only while the separator byte is in flight.
  assign load_sep_o   = (idle_start_s && (seg_len_i == LEN_ZERO)) ||
                        (hs_s && (remaining_q == LEN_ONE));
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_valid_o = valid_q;

  // State sequencing with registered status and valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= LEN_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            remaining_q <= seg_len_i;
            if (seg_len_i != LEN_ZERO) begin
              state_q <= FETCH;
            end else begin
`ifdef ROM_READER_SEPARATOR_EN
              state_q <= FETCH;
`else
              state_q <= FIN;
              done_q  <= 1'b1;
`endif
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        FETCH: begin
          state_q <= WAIT;
        end
        WAIT: begin
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (out_ready_i) begin
            valid_q <= 1'b0;
            if (remaining_q > LEN_ONE) begin
              remaining_q <= remaining_q - LEN_ONE;
              state_q     <= FETCH;
            end
`ifdef ROM_READER_SEPARATOR_EN
            else if (remaining_q == LEN_ONE) begin
              remaining_q <= LEN_ZERO;
              state_q     <= FETCH;
            end
`endif
            else begin
              remaining_q <= LEN_ZERO;
              state_q     <= FIN;
              done_q      <= 1'b1;
            end
          end else begin
            valid_q <= 1'b1;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          remaining_q <= LEN_ZERO;
          busy_q      <= 1'b0;
          valid_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Streams a segment of the 64x8 character ROM out on a valid/ready byte port.
// Optional macro ROM_READER_SEPARATOR_EN appends the separator byte at SEP_ADDR.
module rom_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
`ifdef ROM_READER_SEPARATOR_EN
  parameter logic [ADDR_W-1:0] SEP_ADDR = ADDR_W'(ROM_SEP_ADDR),
`endif
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_reader_if.master bus
);

  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic              load_base_s;
  logic              incr_addr_s;
  logic              capture_s;
  logic              busy_s;
  logic              done_s;
  logic              valid_s;
`ifdef ROM_READER_SEPARATOR_EN
  logic              load_sep_s;
`endif

  rom_reader_fsm #(
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (bus.start),
    .seg_len_i  (bus.seg_len),
    .out_ready_i(bus.out_ready),
    .busy_o     (busy_s),
    .done_o     (done_s),
    .out_valid_o(valid_s),
    .load_base_o(load_base_s),
    .incr_addr_o(incr_addr_s),
`ifdef ROM_READER_SEPARATOR_EN
    .load_sep_o (load_sep_s),
`endif
    .capture_o  (capture_s)
  );

  // Next ROM address; the increment wraps naturally at 2**ADDR_W.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (load_base_s) begin
      rom_addr_d = bus.seg_base;
    end
`ifdef ROM_READER_SEPARATOR_EN
    else if (load_sep_s) begin
      rom_addr_d = SEP_ADDR;
    end
`endif
    else if (incr_addr_s) begin
      rom_addr_d = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Capture the ROM word one cycle after its address was presented.
  always_comb begin
    out_data_d = out_data_q;
    if (capture_s) begin
      out_data_d = bus.rom_d;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= {ADDR_W{1'b0}};
      out_data_q <= {DATA_W{1'b0}};
    end else begin
      rom_addr_q <= rom_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = valid_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: table of named segments, hand sequences
// for stall/restart/reset, and randomized segments against a ROM-content model.
`timescale 1ns/1ps
module tb_rom_reader;
  import rom_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_reader_if bus ();

  rom_reader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Character ROM: 1-cycle registered read. Unmapped words read as 0 here.
  logic [7:0] rom_mem [64];
  logic       rom_map [64];
  always @(posedge clk) bus.rom_d <= rom_map[bus.rom_addr] ? rom_mem[bus.rom_addr] : 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int dones, first_obs, done_obs, last_hs;

  typedef struct {
    logic [5:0]   base;
    logic [5:0]   len;
    int           mode;      // 0: ready=1, 1: stall one byte, 2: random ready
    int           stall_idx;
    int           stall_n;
    int           mid;       // observation at which a stray start is pulsed, -1 none
    int           n_exp;
    logic [127:0] txt;       // expected bytes, byte i at [8*i +: 8]
  } vec_t;

  vec_t vecs[7];

  function automatic logic [127:0] pack_txt(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_rom();
    string id_s, fn_s, sn_s;
    id_s = "210168457";
    fn_s = "HECTORGABRIEL";
    sn_s = "BERROSPEBARAJAS";
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = 8'h00;
      rom_map[i] = 1'b0;
    end
    for (int i = 0; i < id_s.len(); i++) begin
      rom_mem[int'(SEG_ID_BASE) + i] = id_s[i];
      rom_map[int'(SEG_ID_BASE) + i] = 1'b1;
    end
    for (int i = 0; i < fn_s.len(); i++) begin
      rom_mem[int'(SEG_FIRST_BASE) + i] = fn_s[i];
      rom_map[int'(SEG_FIRST_BASE) + i] = 1'b1;
    end
    for (int i = 0; i < sn_s.len(); i++) begin
      rom_mem[int'(SEG_SURN_BASE) + i] = sn_s[i];
      rom_map[int'(SEG_SURN_BASE) + i] = 1'b1;
    end
    rom_mem[int'(SEG_SPACE_BASE)] = 8'h20;
    rom_map[int'(SEG_SPACE_BASE)] = 1'b1;
  endtask

  // Drives one start and watches the stream; abort_bytes>=0 returns once that many bytes were taken.
  task automatic run_seg(input logic [5:0] base, input logic [5:0] len, input int mode,
                         input int stall_idx, input int stall_n, input int mid,
                         input int abort_bytes, input string tag);
    int   obs, stalls;
    bit   prev_valid, hs_pending, hs_this, finished, rdy;
    logic [7:0] prev_data;
    got_q.delete();
    dones = 0; first_obs = -1; done_obs = -1; last_hs = -1;
    stalls = 0; prev_valid = 0; prev_data = 8'h00; hs_pending = 0; finished = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.seg_base = base; bus.seg_len = len;
    bus.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    obs = 0;
    while (!finished && obs < 400) begin
      hs_this = hs_pending;
      if (hs_pending) last_hs = obs;
      hs_pending = 0;
      if (abort_bytes >= 0 && got_q.size() == abort_bytes && bus.out_valid) return;
      if (done_obs < 0) chk({tag, " busy_while_active"}, int'(bus.busy), 1);
      if (bus.done) begin
        dones++;
        if (done_obs < 0) done_obs = obs;
      end
      if (hs_this) chk({tag, " valid_drop_after_accept"}, int'(bus.out_valid), 0);
      if (prev_valid && !hs_this) begin
        chk({tag, " hold_valid"}, int'(bus.out_valid), 1);
        chk({tag, " hold_data"}, int'(bus.out_data), int'(prev_data));
      end
      if (bus.out_valid && !prev_valid) begin
        if (first_obs < 0) begin
          first_obs = obs;
          chk({tag, " first_valid_latency"}, obs, 2);
        end else begin
          chk({tag, " byte_gap"}, obs - last_hs, 2);
        end
      end
      if (done_obs >= 0 && obs == done_obs + 1) begin
        chk({tag, " done_one_cycle"}, int'(bus.done), 0);
        chk({tag, " idle_after_done"}, int'(bus.busy), 0);
        finished = 1;
      end
      bus.start = (obs == mid) ? 1'b1 : 1'b0;
      bus.seg_base = 6'($urandom);
      bus.seg_len  = 6'($urandom_range(1, 63));
      case (mode)
        1: begin
          rdy = !(bus.out_valid && got_q.size() == stall_idx && stalls < stall_n);
          if (bus.out_valid && !rdy) stalls++;
        end
        2: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        got_q.push_back(bus.out_data);
        hs_pending = 1;
      end
      prev_valid = bus.out_valid;
      prev_data  = bus.out_data;
      @(negedge clk);
      obs++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    if (!finished) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, obs);
    end
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " done_timing"}, done_obs, (exp_q.size() == 0) ? 0 : last_hs);
  endtask

  task automatic add_separator();
`ifdef ROM_READER_SEPARATOR_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rb, rl;
    int mid;
    load_rom();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.seg_base = 6'd0; bus.seg_len = 6'd0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rom_addr", int'(bus.rom_addr), 0);
    chk("reset out_data", int'(bus.out_data), 0);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    rst_n = 1'b1;

    vecs[0] = '{6'd0,  6'd9,  0, 0,  0, -1, 9,  pack_txt("210168457")};
    vecs[1] = '{6'd9,  6'd6,  1, 1,  5, -1, 6,  pack_txt("HECTOR")};
    vecs[2] = '{6'd0,  6'd0,  0, 0,  0, -1, 0,  pack_txt("")};
    vecs[3] = '{6'd29, 6'd8,  0, 0,  0,  4, 8,  pack_txt("BERROSPE")};
    vecs[4] = '{6'd37, 6'd7,  2, 0,  0, -1, 7,  pack_txt("BARAJAS")};
    vecs[5] = '{6'd29, 6'd15, 1, 14, 3, -1, 15, pack_txt("BERROSPEBARAJAS")};
    vecs[6] = '{6'd47, 6'd1,  0, 0,  0, -1, 1,  pack_txt(" ")};

    for (int v = 0; v < 7; v++) begin
      run_seg(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].stall_idx,
              vecs[v].stall_n, vecs[v].mid, -1, $sformatf("vec%0d", v));
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(vecs[v].txt[8*i +: 8]);
      add_separator();
      compare_stream($sformatf("vec%0d", v));
    end

    // Reset during the 4th byte of BARAJAS, then a clean restart.
    run_seg(6'd37, 6'd7, 0, 0, 0, -1, 3, "rst");
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst rom_addr", int'(bus.rom_addr), 0);
    chk("rst out_data", int'(bus.out_data), 0);
    chk("rst done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no_done", int'(bus.done), 0);
      chk("rst stays_idle", int'(bus.busy), 0);
    end
    run_seg(6'd37, 6'd7, 0, 0, 0, -1, -1, "after_rst");
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(rom_mem[37 + i]);
    add_separator();
    compare_stream("after_rst");

    // Randomized segments: expected stream is simply the ROM text from base.
    for (int t = 0; t < 25; t++) begin
      rb = 6'($urandom_range(0, 43));
      rl = 6'($urandom_range(0, (44 - int'(rb)) > 20 ? 20 : (44 - int'(rb))));
      exp_q.delete();
      for (int i = 0; i < int'(rl); i++) exp_q.push_back(rom_mem[(int'(rb) + i) % 64]);
      add_separator();
      mid = (exp_q.size() > 0 && $urandom_range(0, 1) == 1) ? 1 : -1;
      run_seg(rb, rl, 2, 0, 0, mid, -1, $sformatf("rnd%0d", t));
      compare_stream($sformatf("rnd%0d b%0d l%0d", t, rb, rl));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
